// File: rtl/ik_swift_hps_st_channel_filter.sv
// Avalon-ST channel narrower/filter: drops whole packets whose SOP channel exceeds MAX_CHANNEL.
// 1-cycle latency through a 2-entry buffer; in_ready depends only on registered occupancy.
module ik_swift_hps_st_channel_filter #(
  parameter int DATA_W        = 8,
  parameter int IN_CHANNEL_W  = 8,
  parameter int OUT_CHANNEL_W = 2,
  parameter int MAX_CHANNEL   = 0,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [IN_CHANNEL_W-1:0]  in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [OUT_CHANNEL_W-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CNT_W-1:0]         drop_pkt_count,
  output logic [CNT_W-1:0]         proto_err_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0]        data;
    logic [OUT_CHANNEL_W-1:0] ch;
    logic                     sop;
    logic                     eop;
  } beat_t;

  localparam logic [IN_CHANNEL_W-1:0] MAX_CH  = IN_CHANNEL_W'(MAX_CHANNEL);
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;

  state_t                   state_q, state_d;
  logic [OUT_CHANNEL_W-1:0] ch_q, ch_d;
  beat_t [1:0]              mem_q, mem_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [CNT_W-1:0]         drop_q, drop_d;
  logic [CNT_W-1:0]         perr_q, perr_d;

  logic  acc, dlv, wr;
  beat_t wbeat;

  assign in_ready          = (cnt_q != 2'd2);
  assign out_valid         = (cnt_q != 2'd0);
  assign out_data          = mem_q[rd_ptr_q].data;
  assign out_channel       = mem_q[rd_ptr_q].ch;
  assign out_startofpacket = mem_q[rd_ptr_q].sop;
  assign out_endofpacket   = mem_q[rd_ptr_q].eop;
  assign drop_pkt_count    = drop_q;
  assign proto_err_count   = perr_q;

  always_comb begin
    acc        = in_valid && in_ready;
    dlv        = out_valid && out_ready;
    state_d    = state_q;
    ch_d       = ch_q;
    wr         = 1'b0;
    drop_d     = drop_q;
    perr_d     = perr_q;
    wbeat.data = in_data;
    wbeat.ch   = ch_q;
    wbeat.sop  = in_startofpacket;
    wbeat.eop  = in_endofpacket;

    if (acc) begin
      // Any SOP restarts evaluation, truncating a packet still in PASS.
      if (in_startofpacket) begin
        if (in_channel <= MAX_CH) begin
          wr       = 1'b1;
          ch_d     = in_channel[OUT_CHANNEL_W-1:0];
          wbeat.ch = in_channel[OUT_CHANNEL_W-1:0];
          state_d  = in_endofpacket ? ST_IDLE : ST_PASS;
        end else begin
          if (drop_q != CNT_MAX) drop_d = drop_q + 1'b1;
          state_d = in_endofpacket ? ST_IDLE : ST_DROP;
        end
      end else begin
        case (state_q)
          ST_PASS: begin
            wr = 1'b1;
            if (in_endofpacket) state_d = ST_IDLE;
          end
          ST_DROP: begin
            if (in_endofpacket) state_d = ST_IDLE;
          end
          default: begin
            if (perr_q != CNT_MAX) perr_d = perr_q + 1'b1;
          end
        endcase
      end
    end

    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = wbeat;
    wr_ptr_d = wr_ptr_q ^ wr;
    rd_ptr_d = rd_ptr_q ^ dlv;
    cnt_d    = cnt_q;
    if (wr && !dlv)      cnt_d = cnt_q + 2'd1;
    else if (!wr && dlv) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      drop_q   <= '0;
      perr_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      perr_q   <= perr_d;
    end
  end

endmodule

// File: tb/tb_ik_swift_hps_st_channel_filter.sv
// Bench for the channel filter: directed packet scenarios plus random traffic against a packet-level model.
module tb_ik_swift_hps_st_channel_filter;

  localparam int DATA_W = 8;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 2;
  localparam int MAXCH  = 1;
  localparam int CNT_W  = 3;
  localparam int CSAT   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_ready, in_valid, in_sop, in_eop;
  logic [DATA_W-1:0] in_data;
  logic [IN_W-1:0]   in_channel;
  logic              out_ready, out_valid, out_sop, out_eop;
  logic [DATA_W-1:0] out_data;
  logic [OUT_W-1:0]  out_channel;
  logic [CNT_W-1:0]  drop_pkt_count, proto_err_count;

  always #5 clk = ~clk;

  ik_swift_hps_st_channel_filter #(
    .DATA_W(DATA_W), .IN_CHANNEL_W(IN_W), .OUT_CHANNEL_W(OUT_W),
    .MAX_CHANNEL(MAXCH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_channel(in_channel), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_channel(out_channel), .out_startofpacket(out_sop), .out_endofpacket(out_eop),
    .drop_pkt_count(drop_pkt_count), .proto_err_count(proto_err_count)
  );

  typedef struct {
    int unsigned d;
    int unsigned ch;
    bit          sop;
    bit          eop;
  } beat_t;

  // Model: expected beats waiting in the DUT, plus whether we are inside a kept/discarded packet.
  beat_t       exp_q[$];
  bit          in_kept_pkt, in_dropped_pkt;
  int unsigned kept_ch;
  int          m_drop, m_perr;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    in_kept_pkt = 0; in_dropped_pkt = 0; kept_ch = 0; m_drop = 0; m_perr = 0;
  endtask

  task automatic model_accept(input int unsigned d, input int unsigned ch, input bit sop, input bit eop);
    beat_t b;
    if (sop) begin
      in_kept_pkt = 0; in_dropped_pkt = 0;
      if (ch <= MAXCH) begin
        kept_ch = ch % (1 << OUT_W);
        b = '{d: d, ch: kept_ch, sop: 1'b1, eop: eop};
        exp_q.push_back(b);
        in_kept_pkt = !eop;
      end else begin
        if (m_drop < CSAT) m_drop++;
        in_dropped_pkt = !eop;
      end
    end else if (in_kept_pkt) begin
      b = '{d: d, ch: kept_ch, sop: 1'b0, eop: eop};
      exp_q.push_back(b);
      if (eop) in_kept_pkt = 0;
    end else if (in_dropped_pkt) begin
      if (eop) in_dropped_pkt = 0;
    end else begin
      if (m_perr < CSAT) m_perr++;
    end
  endtask

  task automatic step(output bit acc);
    bit dlv;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    chk("drop_pkt_count", 32'(drop_pkt_count), 32'(m_drop));
    chk("proto_err_count", 32'(proto_err_count), 32'(m_perr));
    if (out_valid && exp_q.size() != 0) begin
      chk("out_data", 32'(out_data), exp_q[0].d);
      chk("out_channel", 32'(out_channel), exp_q[0].ch);
      chk("out_sop", 32'(out_sop), 32'(exp_q[0].sop));
      chk("out_eop", 32'(out_eop), 32'(exp_q[0].eop));
    end
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
    if (dlv && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) model_accept(in_data, in_channel, in_sop, in_eop);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic drive(input int unsigned d, input int unsigned ch, input bit sop, input bit eop);
    in_valid = 1'b1; in_data = DATA_W'(d); in_channel = IN_W'(ch); in_sop = sop; in_eop = eop;
  endtask

  task automatic wait_acc(input bit rand_rdy);
    bit a = 0;
    for (int i = 0; i < 64 && !a; i++) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      step(a);
    end
    if (!a) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input int unsigned d, input int unsigned ch, input bit sop, input bit eop);
    drive(d, ch, sop, eop);
    wait_acc(1'b0);
  endtask

  task automatic send_pkt(input int unsigned d0, input int unsigned ch, input int len);
    for (int i = 0; i < len; i++)
      send(d0 + i, (i == 0) ? ch : 8'hA5, i == 0, i == len - 1);
  endtask

  initial begin
    bit a;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_channel = '0;
    in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_channel", 32'(out_channel), 32'd0);
    chk("reset_out_sop_eop", 32'({out_sop, out_eop}), 32'd0);
    chk("reset_drop_cnt", 32'(drop_pkt_count), 32'd0);
    chk("reset_perr_cnt", 32'(proto_err_count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // 4-beat in-range packet, continuous sink.
    send_pkt(11, 0, 4);
    idle(3);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // Out-of-range packet disappears whole, following in-range packet passes.
    send_pkt(40, 2, 3);
    send_pkt(50, 0, 2);
    idle(3);
    chk("t2_drop_cnt", 32'(drop_pkt_count), 32'd1);

    // Sink stalls: third beat must wait until out_ready returns.
    out_ready = 1'b0;
    send(60, 0, 1, 0);
    send(61, 0, 0, 0);
    drive(62, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(a);
    chk("t3_in_ready_low", 32'(in_ready), 32'd0);
    chk("t3_buffer_full", 32'(exp_q.size()), 32'd2);
    out_ready = 1'b1;
    wait_acc(1'b0);
    send(63, 0, 0, 1);
    idle(3);

    // Mid-packet channel changes are ignored; channel latched at SOP.
    send(70, 1, 1, 0);
    send(71, 7, 0, 0);
    send(72, 3, 0, 1);
    idle(3);

    // Beat outside a packet, then a single-beat packet.
    send(80, 0, 0, 0);
    send(81, 0, 1, 1);
    idle(3);
    chk("t5_perr_cnt", 32'(proto_err_count), 32'd1);

    // New SOP truncates a passing packet without counting an error.
    send(90, 1, 1, 0);
    send(91, 0, 1, 0);
    send(92, 0, 0, 1);
    idle(3);

    // Drop counter saturates.
    for (int p = 0; p < 9; p++) send_pkt(100, 3, 2);
    idle(2);
    chk("t6_drop_sat", 32'(drop_pkt_count), 32'(CSAT));

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) idle(1);
      else begin
        drive($urandom_range(0, 255),
              ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3),
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        wait_acc(1'b1);
      end
    end
    out_ready = 1'b1;
    idle(4);

    // Reset in the middle of a kept packet.
    send(120, 0, 1, 0);
    out_ready = 1'b0;
    send(121, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    out_ready = 1'b1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_drop_cnt", 32'(drop_pkt_count), 32'd0);
    chk("rst_mid_perr_cnt", 32'(proto_err_count), 32'd0);
    send(122, 0, 0, 1);
    idle(2);
    chk("rst_mid_perr_after", 32'(proto_err_count), 32'd1);
    send(123, 1, 1, 1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
